uart_ctrl: RTL and testbench

Bus-side controller for the board UART. It sits between the CPU's peripheral bus and the UART transmitter/receiver pair, and buffers traffic in each direction with a small FIFO. It sequences the transmitter's start/busy handshake one byte at a time, captures received bytes on the receiver's ready pulse, and exposes data, status and control registers plus one level interrupt.

---
 rtl/uart_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-side controller for the board UART.
// Buffers CPU writes in a TX FIFO and feeds the transmitter one byte at a
// time through a start/busy handshake. Buffers received bytes in an RX FIFO.
// Registers: 0 DATA (push TX / pop RX), 1 STATUS (ro), 2 CTRL, 3 reserved.
// Ports:
//   clk, rst (async, active-low)
//   bus_ce/bus_we/bus_addr/bus_wdata -> bus_rdata/bus_ack (one cycle later)
//   irq                              level interrupt, registered
//   uart_tx_data/uart_tx_start_n     byte + active-low start pulse
//   uart_tx_busy                     transmitter busy
//   uart_rx_data/uart_rx_ready       received byte + one-cycle valid pulse
module uart_ctrl #(
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_ce,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        irq,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_start_n,
  input  logic        uart_tx_busy,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_ready
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TW  = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TAW:0]  TX_FULL  = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0]  RX_FULL  = (RAW+1)'(RX_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} tx_state_t;
  tx_state_t state, state_nxt;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [TAW:0]   tx_cnt;
  logic [RAW:0]   rx_cnt;
  logic [TW-1:0]  tmo_cnt;
  logic           rx_ie, tx_ie, rx_overrun, tx_drop;

  logic data_wr, data_rd, stat_rd, ctrl_wr, flush;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_active;
  logic tx_push, tx_pop, rx_push, rx_pop, tmo_hit;
  logic rx_ovr_set, tx_drop_set;
  logic [31:0] status_word, rdata_nxt;
  logic unused_wdata;

  assign unused_wdata = ^bus_wdata[31:8];

  assign data_wr = bus_ce &  bus_we & (bus_addr == 2'd0);
  assign data_rd = bus_ce & ~bus_we & (bus_addr == 2'd0);
  assign stat_rd = bus_ce & ~bus_we & (bus_addr == 2'd1);
  assign ctrl_wr = bus_ce &  bus_we & (bus_addr == 2'd2);
  assign flush   = ctrl_wr & bus_wdata[2];

  assign tx_full   = (tx_cnt == TX_FULL);
  assign tx_empty  = (tx_cnt == '0);
  assign rx_full   = (rx_cnt == RX_FULL);
  assign rx_empty  = (rx_cnt == '0);
  assign tx_active = (state != IDLE);

  assign tx_push = data_wr & ~tx_full;
  assign rx_pop  = data_rd & ~rx_empty;
  // A pop in the same cycle frees the slot, so a capture at full is accepted.
  assign rx_push     = uart_rx_ready & (~rx_full | rx_pop);
  assign rx_ovr_set  = uart_rx_ready & rx_full & ~rx_pop;
  assign tx_drop_set = (data_wr & tx_full) | tmo_hit;

  // TX sequencer
  always_comb begin
    state_nxt = state;
    tx_pop    = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE:
        if (!tx_empty && !uart_tx_busy) begin
          tx_pop    = 1'b1;
          state_nxt = START;
        end
      START: state_nxt = WAIT_BUSY;
      WAIT_BUSY:
        if (uart_tx_busy) state_nxt = WAIT_DONE;
        else if (tmo_cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      WAIT_DONE: if (!uart_tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  // Decoded from the state register so reset forces it high with no clock.
  assign uart_tx_start_n = (state != START);

  always_ff @(posedge clk or negedge rst)
    if (!rst)                   tmo_cnt <= '0;
    else if (state == START)    tmo_cnt <= '0;
    else if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst)
    if (!rst)        uart_tx_data <= '0;
    else if (tx_pop) uart_tx_data <= tx_mem[tx_rp];

  // FIFO storage (no reset needed, guarded by counts)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus_wdata[7:0];
    if (rx_push) rx_mem[rx_wp] <= uart_rx_data;
  end

  // Flush empties both FIFOs; a byte already popped into uart_tx_data still goes out.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else if (flush) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push & ~tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (~tx_push & tx_pop) tx_cnt <= tx_cnt - 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push & ~rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (~rx_push & rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end

  // Sticky flags: a new event in the same cycle as a STATUS read survives,
  // since that read could not have reported it.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_overrun <= 1'b0; tx_drop <= 1'b0;
    end else if (flush) begin
      rx_overrun <= 1'b0; tx_drop <= 1'b0;
    end else begin
      if (rx_ovr_set)   rx_overrun <= 1'b1;
      else if (stat_rd) rx_overrun <= 1'b0;
      if (tx_drop_set)  tx_drop <= 1'b1;
      else if (stat_rd) tx_drop <= 1'b0;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_ie <= 1'b0; tx_ie <= 1'b0;
    end else if (ctrl_wr) begin
      rx_ie <= bus_wdata[0]; tx_ie <= bus_wdata[1];
    end

  assign status_word = {16'd0, 8'(rx_cnt), 2'b00, tx_drop, tx_active,
                        rx_overrun, tx_empty, tx_full, ~rx_empty};

  always_comb begin
    rdata_nxt = '0;
    case (bus_addr)
      2'd0:    rdata_nxt = {24'd0, rx_empty ? 8'd0 : rx_mem[rx_rp]};
      2'd1:    rdata_nxt = status_word;
      2'd2:    rdata_nxt = {30'd0, tx_ie, rx_ie};
      default: rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus_ack <= 1'b0; bus_rdata <= '0; irq <= 1'b0;
    end else begin
      bus_ack   <= bus_ce;
      bus_rdata <= (bus_ce & ~bus_we) ? rdata_nxt : '0;
      irq       <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_active);
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: register table, directed multi-cycle
// sequences with a behavioural transmitter, and a randomized run against a
// queue-based reference model.
module tb_uart_ctrl;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int B_NORM = 0, B_HIGH = 1, B_LOW = 2;

  logic        clk = 0, rst = 1;
  logic        bus_ce = 0, bus_we = 0;
  logic [1:0]  bus_addr = 0;
  logic [31:0] bus_wdata = 0, bus_rdata;
  logic        bus_ack, irq;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start_n;
  logic        uart_tx_busy = 0;
  logic [7:0]  uart_rx_data = 0;
  logic        uart_rx_ready = 0;

  int checks = 0, failures = 0;
  int cyc = 0;
  int bmode = B_HIGH;
  int busy_len = 20;
  int rise_in = 0, hi_left = 0, last_hi = -100;

  typedef struct {logic [7:0] d; int c; logic b; int gap;} st_t;
  st_t starts[$];

  uart_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .bus_ce(bus_ce), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .irq(irq),
    .uart_tx_data(uart_tx_data), .uart_tx_start_n(uart_tx_start_n),
    .uart_tx_busy(uart_tx_busy), .uart_rx_data(uart_rx_data),
    .uart_rx_ready(uart_rx_ready));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Behavioural transmitter: busy rises 2 cycles after a start, stays high busy_len cycles.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      uart_tx_busy = 0; rise_in = 0; hi_left = 0;
    end else if (bmode == B_HIGH) uart_tx_busy = 1;
    else if (bmode == B_LOW) uart_tx_busy = 0;
    else begin
      if (hi_left > 0) begin
        hi_left--;
        if (hi_left == 0) uart_tx_busy = 0;
      end else if (rise_in > 0) begin
        rise_in--;
        if (rise_in == 0) begin uart_tx_busy = 1; hi_left = busy_len; end
      end
      if (!uart_tx_start_n) rise_in = 2;
    end
  end

  // Start-pulse monitor
  always @(posedge clk) begin
    #2;
    if (rst && !uart_tx_start_n) starts.push_back('{uart_tx_data, cyc, uart_tx_busy, cyc - last_hi});
    if (uart_tx_busy) last_hi = cyc;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic ce, input logic we, input logic [1:0] a, input logic [31:0] wd,
                      input logic rr, input logic [7:0] rxd,
                      output logic [31:0] rdo, output logic acko);
    bus_ce = ce; bus_we = we; bus_addr = a; bus_wdata = wd;
    uart_rx_ready = rr; uart_rx_data = rxd;
    @(posedge clk); #1;
    bus_ce = 0; bus_we = 0; uart_rx_ready = 0;
    rdo = bus_rdata; acko = bus_ack;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r; logic k;
    step(1, 1, a, d, 0, 0, r, k);
    chk("wr_ack", 32'(k), 1);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] r; logic k;
    step(1, 0, a, 0, 0, 0, r, k);
    chk({nm, "_ack"}, 32'(k), 1);
    chk(nm, r, exp);
  endtask

  task automatic rx(input logic [7:0] d);
    logic [31:0] r; logic k;
    step(0, 0, 0, 0, 1, d, r, k);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 0; bus_ce = 0; bus_we = 0; uart_rx_ready = 0;
    idle(2);
    rst = 1;
    idle(2);
    starts.delete();
  endtask

  function automatic logic [31:0] mstat(int rxn, int txn, bit ovr, bit drop);
    return {16'd0, 8'(rxn), 2'b00, drop, 1'b0, ovr, (txn == 0), (txn == TXD), (rxn != 0)};
  endfunction

  typedef struct {logic we; logic [1:0] addr; logic [31:0] wdata; logic [31:0] exp; string nm;} vec_t;
  vec_t vt[13];

  initial begin
    logic [31:0] r; logic k;
    byte unsigned txq[$], rxq[$];
    bit m_rxie, m_txie, m_ovr, m_drop;

    vt[0]  = '{0, 2'd1, 32'h0,   32'h4, "tbl_status_rst"};
    vt[1]  = '{0, 2'd2, 32'h0,   32'h0, "tbl_ctrl_rst"};
    vt[2]  = '{0, 2'd0, 32'h0,   32'h0, "tbl_data_empty"};
    vt[3]  = '{1, 2'd2, 32'h3,   32'h0, "tbl_ctrl_wr3"};
    vt[4]  = '{0, 2'd2, 32'h0,   32'h3, "tbl_ctrl_rd3"};
    vt[5]  = '{1, 2'd2, 32'h7,   32'h0, "tbl_ctrl_wr7"};
    vt[6]  = '{0, 2'd2, 32'h0,   32'h3, "tbl_flush_rd0"};
    vt[7]  = '{1, 2'd0, 32'h1AB, 32'h0, "tbl_data_wr"};
    vt[8]  = '{0, 2'd1, 32'h0,   32'h0, "tbl_status_tx1"};
    vt[9]  = '{0, 2'd3, 32'h0,   32'h0, "tbl_reserved"};
    vt[10] = '{1, 2'd2, 32'h4,   32'h0, "tbl_flush"};
    vt[11] = '{0, 2'd2, 32'h0,   32'h0, "tbl_ctrl_rd0"};
    vt[12] = '{0, 2'd1, 32'h0,   32'h4, "tbl_status_flushed"};

    // Reset values, checked while reset is held
    #2 rst = 0;
    #1;
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_ack", 32'(bus_ack), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_txdata", 32'(uart_tx_data), 0);
    chk("rst_start_n", 32'(uart_tx_start_n), 1);
    idle(2); rst = 1; idle(2);

    // Register table (transmitter held busy so the TX FIFO stays put)
    bmode = B_HIGH; do_reset();
    foreach (vt[i]) begin
      step(1, vt[i].we, vt[i].addr, vt[i].wdata, 0, 0, r, k);
      chk({vt[i].nm, "_ack"}, 32'(k), 1);
      if (!vt[i].we) chk(vt[i].nm, r, vt[i].exp);
    end

    // TX path with three bytes
    bmode = B_NORM; busy_len = 20; do_reset();
    begin
      int wc;
      wc = cyc;
      wr(0, 32'h41); wr(0, 32'h42); wr(0, 32'h43);
      idle(120);
      chk("tx_nstarts", starts.size(), 3);
      if (starts.size() == 3) begin
        chk("tx_latency", starts[0].c, wc + 2);
        for (int i = 0; i < 3; i++) begin
          chk("tx_byte", 32'(starts[i].d), 32'h41 + i);
          chk("tx_busy_at_start", 32'(starts[i].b), 0);
          if (i > 0) chk("tx_gap_ok", 32'(starts[i].gap >= 3), 1);
        end
      end
      rd_chk("tx_status_done", 1, 32'h0004);
    end

    // TX overflow
    bmode = B_HIGH; do_reset();
    for (int i = 0; i < 9; i++) wr(0, 32'h60 + i);
    rd_chk("ovf_status1", 1, 32'h0022);
    rd_chk("ovf_status2", 1, 32'h0002);
    chk("ovf_nstarts", starts.size(), 0);

    // RX overrun
    do_reset();
    for (int i = 0; i < 9; i++) rx(8'h10 + 8'(i));
    rd_chk("rxo_status", 1, 32'h080D);
    for (int i = 0; i < 8; i++) rd_chk("rxo_data", 0, 32'h10 + i);
    rd_chk("rxo_data_empty", 0, 0);
    rd_chk("rxo_status2", 1, 32'h0004);

    // RX capture at full with a simultaneous pop
    do_reset();
    for (int i = 0; i < 8; i++) rx(8'h20 + 8'(i));
    step(1, 0, 0, 0, 1, 8'h28, r, k);
    chk("rxf_pop_data", r, 32'h20);
    rd_chk("rxf_status", 1, 32'h0805);
    for (int i = 0; i < 8; i++) rd_chk("rxf_data", 0, 32'h21 + i);

    // Interrupts
    bmode = B_NORM; do_reset();
    wr(2, 32'h1);
    rx(8'h5C);
    chk("irq_rx_n1", 32'(irq), 0);
    idle(1);
    chk("irq_rx_n2", 32'(irq), 1);
    rd_chk("irq_rx_data", 0, 32'h5C);
    idle(1);
    chk("irq_rx_clear", 32'(irq), 0);
    wr(2, 32'h2);
    idle(1);
    chk("irq_tx_idle", 32'(irq), 1);

    // Busy timeout
    bmode = B_LOW; do_reset();
    wr(0, 32'h5A);
    idle(5);
    rd_chk("tmo_status_active", 1, 32'h0014);
    rd_chk("tmo_status_idle", 1, 32'h0024);
    rd_chk("tmo_status_clr", 1, 32'h0004);
    chk("tmo_nstarts", starts.size(), 1);
    if (starts.size() == 1) chk("tmo_byte", 32'(starts[0].d), 32'h5A);

    // Async reset during START
    bmode = B_NORM; busy_len = 20; do_reset();
    wr(0, 32'h33);
    idle(1);
    chk("ar_start_low", 32'(uart_tx_start_n), 0);
    #2 rst = 0; #1;
    chk("ar_start_forced", 32'(uart_tx_start_n), 1);
    chk("ar_txdata0", 32'(uart_tx_data), 0);

    // Async reset during WAIT_DONE
    do_reset();
    wr(2, 32'h1);
    rx(8'h99);
    wr(0, 32'h77);
    idle(8);
    chk("rwd_pre_irq", 32'(irq), 1);
    chk("rwd_pre_txdata", 32'(uart_tx_data), 32'h77);
    #2 rst = 0; #1;
    chk("rwd_irq", 32'(irq), 0);
    chk("rwd_txdata", 32'(uart_tx_data), 0);
    chk("rwd_start_n", 32'(uart_tx_start_n), 1);
    chk("rwd_ack", 32'(bus_ack), 0);
    chk("rwd_rdata", bus_rdata, 0);
    do_reset();
    rd_chk("rwd_status_after", 1, 32'h0004);

    // Randomized run against the queue model (transmitter held busy)
    bmode = B_HIGH; do_reset();
    txq.delete(); rxq.delete();
    m_rxie = 0; m_txie = 0; m_ovr = 0; m_drop = 0;
    for (int it = 0; it < 400; it++) begin
      int rsel;
      logic ce, we, rr, exp_irq;
      logic [1:0] a;
      logic [31:0] wd, exp_rd;
      logic [7:0] rxd;
      bit full_rx, popped;
      rsel = $urandom_range(0, 99);
      ce = 1; we = 0; a = 0; wd = $urandom;
      if (rsel < 30)      begin we = 1; a = 0; end
      else if (rsel < 55) a = 0;
      else if (rsel < 70) a = 1;
      else if (rsel < 80) begin we = 1; a = 2; wd[2] = ($urandom_range(0, 7) == 0); end
      else if (rsel < 85) a = 2;
      else if (rsel < 90) begin a = 3; we = 1'($urandom_range(0, 1)); end
      else if (rsel < 93) begin a = 1; we = 1; end
      else ce = 0;
      rr = ($urandom_range(0, 2) == 0);
      rxd = 8'($urandom);

      exp_irq = (m_rxie && rxq.size() > 0) || (m_txie && txq.size() == 0);
      exp_rd = 0;
      if (a == 0)      exp_rd = (rxq.size() > 0) ? 32'(rxq[0]) : 0;
      else if (a == 1) exp_rd = mstat(rxq.size(), txq.size(), m_ovr, m_drop);
      else if (a == 2) exp_rd = {30'd0, m_txie, m_rxie};

      step(ce, we, a, wd, rr, rxd, r, k);
      chk("rnd_ack", 32'(k), 32'(ce));
      if (ce && !we) chk("rnd_rdata", r, exp_rd);
      chk("rnd_irq", 32'(irq), 32'(exp_irq));

      full_rx = (rxq.size() == RXD); popped = 0;
      if (ce && !we && a == 1) begin m_ovr = 0; m_drop = 0; end
      if (ce && we && a == 0) begin
        if (txq.size() == TXD) m_drop = 1;
        else txq.push_back(wd[7:0]);
      end
      if (ce && !we && a == 0 && rxq.size() > 0) begin
        void'(rxq.pop_front()); popped = 1;
      end
      if (rr) begin
        if (full_rx && !popped) m_ovr = 1;
        else rxq.push_back(rxd);
      end
      if (ce && we && a == 2) begin
        m_rxie = wd[0]; m_txie = wd[1];
        if (wd[2]) begin txq.delete(); rxq.delete(); m_ovr = 0; m_drop = 0; end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
